bp_me_mem_cmd_responder: RTL
============================

Name: bp_me_mem_cmd_responder

Overview:
- Synthesizable BedRock memory-side responder that terminates the cce-mem interface driven by an I$/UCE or CCE.
- Accepts one mem_cmd at a time, performs the read or write on an internal block store, and returns a mem_resp after a programmable latency.
- Serves as a lightweight memory endpoint for FE/ME subsystem benches and small FPGA configurations where full bp_mem with DRAM models is unnecessary.

Parameters:
- bp_params_p, e_bp_default_cfg, selects paddr_width_p, cce_block_width_p, lce_id_width_p, lce_assoc_p.
- els_p, 1024, number of cce_block_width_p-wide blocks in the store.
- mem_offset_p, dram_base_addr_gp, physical address mapped to block 0.
- latency_p, 4, idle cycles between command acceptance and response valid (0 legal).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- mem_cmd_i  in  cce_mem_msg_width_lp  bp_bedrock_cce_mem_msg_s command (header plus block data).
- mem_cmd_v_i  in  1  command valid.
- mem_cmd_ready_o  out  1  ready-valid handshake: accept when v&ready.
- mem_resp_o  out  cce_mem_msg_width_lp  response message.
- mem_resp_v_o  out  1  response valid.
- mem_resp_yumi_i  in  1  consumer takes response; legal only when mem_resp_v_o is high.

Behaviour:
- Reset values: mem_cmd_ready_o=0 during reset and 1 in the first cycle after; mem_resp_v_o=0; mem_resp_o=0.
- Store contents are not cleared by reset.
- FSM states:
  - e_reset → e_ready on the first non-reset cycle.
  - e_ready (ready=1): on v&ready, latch the header and data, load counter=latency_p, then go to e_wait, or directly to e_access if latency_p=0.
  - e_wait: decrement the counter each cycle; at 0, go to e_access.
  - e_access: issue a single store read or write; go to e_resp the next cycle.
  - e_resp: mem_resp_v_o=1 with a stable payload until yumi; on yumi, return to e_ready.
- Latency: a command accepted at cycle t gives mem_resp_v_o=1 at cycle t+2+latency_p.
- Ready and response valid are never both high, so at most one command is outstanding.
- Response header echoes the command msg_type, addr, size and payload unchanged.
- Index computation: index=((addr-mem_offset_p)>>log2(cce_block_width_p/8)) mod els_p. Addresses below mem_offset_p or with index≥els_p are out of range.
- Byte offset: off=addr[log2(block_bytes)-1:0], aligned down to 2^size bytes.
- e_bedrock_mem_rd / e_bedrock_mem_uc_rd:
  - size=block: return the whole block.
  - size<block: return the 2^size bytes at off, replicated across the full data width.
  - Out of range: data=0.
- e_bedrock_mem_wr / e_bedrock_mem_uc_wr:
  - Write mem_cmd_i.data[0+:8*2^size] into bytes off..off+2^size-1; other bytes are untouched.
  - Response data=0.
  - Out of range: write dropped, response still returned.
- Any other msg_type: no store access; respond with data=0 (no hang).
- Reset asserted mid-operation: the pending command is discarded, no response is issued, and a write not yet in e_access is not performed.
- yumi when not valid: ignored. An assertion fires in simulation.

Decomposition:
- Shared package (bp_me_pkg): the state enum bp_me_mem_responder_state_e.
- Message struct and msg_type values come from the existing bedrock mem declare macros.
- Sub-module bp_me_mem_responder_store contains:
  - the synchronous 1RW byte-masked array (els_p x cce_block_width_p);
  - the size/offset-to-byte-mask logic;
  - the read replicate logic.

Test Plan:
- Reset then idle → ready=1 at the first post-reset cycle, resp_v=0 for 20 cycles.
- wr addr=mem_offset_p+0x40, size=64B, data=0xA5 pattern, latency_p=4 → resp_v at accept+6; next rd of the same address returns 0xA5 pattern, header echoed.
- uc_wr 8B 0x1122334455667788 at offset 0x48 → rd 8B at 0x48 returns that value replicated 8x across 512 bits; a full-block rd shows other bytes unchanged.
- Out-of-range rd at mem_offset_p-0x40 → response with data=0. Wr to index els_p is dropped, and block 0 is unchanged.
- Response backpressure: hold yumi=0 for 10 cycles → resp_o stable, ready=0 throughout, a second command is not accepted until the cycle after yumi.
- Reset asserted in e_wait with a pending wr → no response; subsequent rd of that address returns the pre-write value. With latency_p=0, response at accept+2.

Source files
------------

// File: rtl/bp_me_pkg.sv
// bp_me_pkg: BedRock cce-mem message types and responder FSM states
package bp_me_pkg;

    localparam int paddr_width_gp     = 40;
    localparam int cce_block_width_gp = 512;
    localparam int block_bytes_gp     = cce_block_width_gp / 8;
    localparam int lg_block_bytes_gp  = $clog2(block_bytes_gp);
    localparam int lce_id_width_gp    = 4;
    localparam int lce_assoc_gp       = 8;
    localparam logic [paddr_width_gp-1:0] dram_base_addr_gp = 40'h00_8000_0000;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_amo   = 4'd4
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [lce_id_width_gp-1:0]       lce_id;
        logic [$clog2(lce_assoc_gp)-1:0]  way_id;
    } bp_bedrock_cce_mem_payload_s;

    typedef struct packed {
        bp_bedrock_mem_type_e         msg_type;
        logic [paddr_width_gp-1:0]    addr;
        bp_bedrock_msg_size_e         size;
        bp_bedrock_cce_mem_payload_s  payload;
    } bp_bedrock_cce_mem_header_s;

    typedef struct packed {
        bp_bedrock_cce_mem_header_s       header;
        logic [cce_block_width_gp-1:0]    data;
    } bp_bedrock_cce_mem_msg_s;

    localparam int cce_mem_msg_width_gp = $bits(bp_bedrock_cce_mem_msg_s);

    typedef enum logic [2:0] {
        e_reset,
        e_ready,
        e_wait,
        e_access,
        e_resp
    } bp_me_mem_responder_state_e;

    function automatic logic [lg_block_bytes_gp-1:0] size_mask(input bp_bedrock_msg_size_e s);
        return (int'(s) >= lg_block_bytes_gp) ? '1 : lg_block_bytes_gp'((1 << s) - 1);
    endfunction

endpackage

// File: rtl/bp_me_mem_responder_store.sv
// bp_me_mem_responder_store: 1RW byte-masked block store with sub-block read replication
module bp_me_mem_responder_store
    import bp_me_pkg::*;
#(
    parameter int els_p    = 1024,
    parameter int lg_els_p = $clog2(els_p)
) (
    input  logic                           clk_i,
    input  logic                           v_i,
    input  logic                           w_i,
    input  logic [lg_els_p-1:0]            index_i,
    input  bp_bedrock_msg_size_e           size_i,
    input  logic [lg_block_bytes_gp-1:0]   off_i,
    input  logic [cce_block_width_gp-1:0]  data_i,
    output logic [cce_block_width_gp-1:0]  data_o
);
    logic [cce_block_width_gp-1:0] mem [els_p];
    logic [cce_block_width_gp-1:0] blk_r;
    logic [lg_block_bytes_gp-1:0] mask, base, mask_r, base_r;

    assign mask = size_mask(size_i);
    assign base = off_i & ~mask;

    always_ff @(posedge clk_i) begin
        if (v_i && w_i)
            for (int i = 0; i < block_bytes_gp; i++)
                if ((lg_block_bytes_gp'(i) & ~mask) == base)
                    mem[index_i][8*i+:8] <= data_i[8*(lg_block_bytes_gp'(i) & mask)+:8];
        if (v_i && !w_i) begin
            blk_r  <= mem[index_i];
            mask_r <= mask;
            base_r <= base;
        end
    end

    // each output byte picks the same lane within the aligned window, replicating it
    always_comb begin
        data_o = '0;
        for (int i = 0; i < block_bytes_gp; i++)
            data_o[8*i+:8] = blk_r[8*(base_r | (lg_block_bytes_gp'(i) & mask_r))+:8];
    end

endmodule

// File: rtl/bp_me_mem_cmd_responder.sv
// bp_me_mem_cmd_responder: single-outstanding cce-mem endpoint with programmable latency
module bp_me_mem_cmd_responder
    import bp_me_pkg::*;
#(
    parameter int                         els_p        = 1024,
    parameter logic [paddr_width_gp-1:0]  mem_offset_p = dram_base_addr_gp,
    parameter int                         latency_p    = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [cce_mem_msg_width_gp-1:0]  mem_cmd_i,
    input  logic                             mem_cmd_v_i,
    output logic                             mem_cmd_ready_o,
    output logic [cce_mem_msg_width_gp-1:0]  mem_resp_o,
    output logic                             mem_resp_v_o,
    input  logic                             mem_resp_yumi_i
);
    localparam int lg_els_lp = $clog2(els_p);
    localparam int cnt_w_lp  = (latency_p > 1) ? $clog2(latency_p) : 1;

    bp_me_mem_responder_state_e state_r, state_n;
    bp_bedrock_cce_mem_msg_s cmd_r, resp;
    logic [cnt_w_lp-1:0] cnt_r, cnt_n;
    logic [paddr_width_gp-1:0] rel;
    logic [cce_block_width_gp-1:0] rdata;
    logic in_range, is_rd, is_wr, rd_hit_r, hs;

    assign rel      = cmd_r.header.addr - mem_offset_p;
    assign in_range = (cmd_r.header.addr >= mem_offset_p)
                    && ((rel >> lg_block_bytes_gp) < paddr_width_gp'(els_p));
    assign is_rd    = cmd_r.header.msg_type inside {e_bedrock_mem_rd, e_bedrock_mem_uc_rd};
    assign is_wr    = cmd_r.header.msg_type inside {e_bedrock_mem_wr, e_bedrock_mem_uc_wr};

    // e_reset also accepts so the first post-reset cycle is already ready
    assign mem_cmd_ready_o = ~reset_i & (state_r == e_reset || state_r == e_ready);
    assign mem_resp_v_o    = ~reset_i & (state_r == e_resp);
    assign hs              = mem_cmd_v_i & mem_cmd_ready_o;

    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        case (state_r)
            e_reset, e_ready: begin
                state_n = hs ? ((latency_p == 0) ? e_access : e_wait) : e_ready;
                cnt_n   = hs ? cnt_w_lp'(latency_p - 1) : cnt_r;
            end
            e_wait: begin
                state_n = (cnt_r == '0) ? e_access : e_wait;
                cnt_n   = (cnt_r == '0) ? cnt_r : cnt_r - 1'b1;
            end
            e_access: state_n = e_resp;
            e_resp:   state_n = mem_resp_yumi_i ? e_ready : e_resp;
            default:  state_n = e_reset;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= e_reset;
            cnt_r    <= '0;
            rd_hit_r <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            if (hs)
                cmd_r <= mem_cmd_i;
            if (state_r == e_access)
                rd_hit_r <= is_rd & in_range;
        end
    end

    bp_me_mem_responder_store #(
        .els_p(els_p)
    ) store (
        .clk_i  (clk_i),
        .v_i    (~reset_i && state_r == e_access && in_range && (is_rd || is_wr)),
        .w_i    (is_wr),
        .index_i(rel[lg_block_bytes_gp+:lg_els_lp]),
        .size_i (cmd_r.header.size),
        .off_i  (cmd_r.header.addr[lg_block_bytes_gp-1:0]),
        .data_i (cmd_r.data),
        .data_o (rdata)
    );

    always_comb begin
        resp = '0;
        if (mem_resp_v_o) begin
            resp.header = cmd_r.header;
            resp.data   = rd_hit_r ? rdata : '0;
        end
    end
    assign mem_resp_o = resp;

    assert property (@(posedge clk_i) disable iff (reset_i) mem_resp_yumi_i |-> mem_resp_v_o);

endmodule
